// File: rtl/logic_unit_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : logic_unit_seq
// Purpose  : Multi-cycle bitwise logic unit. One of eight logic functions is
//            applied to two WIDTH-bit operands. The unit evaluates SLICE bits
//            per cycle, so an operation takes N = WIDTH/SLICE cycles. Zero and
//            parity flags accumulate across the slices. Input and output
//            use valid/ready handshakes.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   A, B and op are valid
//            in_ready   unit can accept an operation
//            A, B       operands (WIDTH bits)
//            op         000 AND, 001 OR, 010 XOR, 011 NOR,
//                       100 XNOR, 101 NAND, 110 ANDN (A & ~B), 111 PASSA
//            out_valid  Logic_out, zero and parity are valid
//            out_ready  consumer takes the result
//            Logic_out  result (WIDTH bits)
//            zero       Logic_out == 0
//            parity     XOR reduction of Logic_out
// Revision : 1.0  initial release
// ============================================================================
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Logic_out,
  output logic             zero,
  output logic             parity
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [2:0]       op_lat;
  logic [CW-1:0]    cnt;
  logic             zero_acc;
  logic             parity_acc;
  logic [SLICE-1:0] slice;
  logic             accept;
  logic             last;

  function automatic logic [SLICE-1:0] slice_fn(input logic [2:0]       f,
                                                 input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y);
    logic [SLICE-1:0] r;
    case (f)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x | y);
      3'b100:  r = ~(x ^ y);
      3'b101:  r = ~(x & y);
      3'b110:  r = x & ~y;
      default: r = x;
    endcase
    return r;
  endfunction

  // in_ready depends combinationally on out_ready in DONE so a result can be
  // consumed and a new operation accepted on the same edge.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(N - 1));

  always_comb begin
    slice = slice_fn(op_lat, a_lat[cnt*SLICE +: SLICE], b_lat[cnt*SLICE +: SLICE]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = in_valid ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat      <= '0;
      b_lat      <= '0;
      op_lat     <= '0;
      cnt        <= '0;
      zero_acc   <= 1'b0;
      parity_acc <= 1'b0;
      Logic_out  <= '0;
      zero       <= 1'b0;
      parity     <= 1'b0;
    end else if (accept) begin
      a_lat      <= A;
      b_lat      <= B;
      op_lat     <= op;
      cnt        <= '0;
      zero_acc   <= 1'b1;
      parity_acc <= 1'b0;
    end else if (state == RUN) begin
      // Only the current slice is written; the rest of Logic_out keeps the
      // previous result until its slice comes round.
      Logic_out[cnt*SLICE +: SLICE] <= slice;
      zero_acc   <= zero_acc & ~(|slice);
      parity_acc <= parity_acc ^ (^slice);
      if (last) begin
        zero   <= zero_acc & ~(|slice);
        parity <= parity_acc ^ (^slice);
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
